// File: rtl/ssds_scan_controller.sv
// Four-digit 7-segment scan controller: shared segment bus, one-hot digit select,
// anti-ghosting blank before each digit slot and 16-level PWM brightness.
module ssds_scan_controller #(
    parameter int SUB_DIV      = 3125,
    parameter int BLANK_CYCLES = 500,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] digit_0,
    input  logic [6:0] digit_1,
    input  logic [6:0] digit_2,
    input  logic [6:0] digit_3,
    input  logic [3:0] dots,
    input  logic [3:0] brightness,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] digit_sel,
    output logic       frame_start
);

    localparam int CNT_MAX = (SUB_DIV > BLANK_CYCLES) ? SUB_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SUB_LAST   = CNT_W'(SUB_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       sub;
    logic [6:0]       seg_snap;
    logic             dp_snap;
    logic [3:0]       bright_snap;
    logic [6:0]       digit_pick;

    // Logical-to-physical conversion; "on" low forces the inactive level.
    function automatic logic [6:0] seg_phys(input logic [6:0] pattern, input logic on);
        logic [6:0] p;
        p = on ? pattern : 7'h00;
        return ACTIVE_LOW ? ~p : p;
    endfunction

    function automatic logic dp_phys(input logic dot, input logic on);
        logic p;
        p = on & dot;
        return ACTIVE_LOW ? ~p : p;
    endfunction

    function automatic logic [3:0] sel_phys(input logic [1:0] which, input logic on);
        logic [3:0] p;
        p = on ? (4'b0001 << which) : 4'b0000;
        return ACTIVE_LOW ? ~p : p;
    endfunction

    always_comb begin
        digit_pick = digit_0;
        case (idx)
            2'd0: digit_pick = digit_0;
            2'd1: digit_pick = digit_1;
            2'd2: digit_pick = digit_2;
            2'd3: digit_pick = digit_3;
            default: digit_pick = digit_0;
        endcase
    end

    // Outputs are computed from the values the state registers take at the same
    // edge, so what leaves the pins always matches the current state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= 2'd0;
            cnt         <= '0;
            sub         <= 4'd0;
            seg_snap    <= 7'h00;
            dp_snap     <= 1'b0;
            bright_snap <= 4'd0;
            seg         <= seg_phys(7'h00, 1'b0);
            dp          <= dp_phys(1'b0, 1'b0);
            digit_sel   <= sel_phys(2'd0, 1'b0);
            frame_start <= 1'b0;
        end else if (!en) begin
            state       <= IDLE;
            idx         <= 2'd0;
            cnt         <= '0;
            sub         <= 4'd0;
            seg         <= seg_phys(seg_snap, 1'b0);
            dp          <= dp_phys(dp_snap, 1'b0);
            digit_sel   <= sel_phys(idx, 1'b0);
            frame_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= BLANK;
                    idx         <= 2'd0;
                    cnt         <= '0;
                    sub         <= 4'd0;
                    seg         <= seg_phys(seg_snap, 1'b0);
                    dp          <= dp_phys(dp_snap, 1'b0);
                    digit_sel   <= sel_phys(2'd0, 1'b0);
                    frame_start <= 1'b1;
                end
                BLANK: begin
                    frame_start <= 1'b0;
                    sub         <= 4'd0;
                    if (cnt == BLANK_LAST) begin
                        // Latch the slot's content so mid-slot input changes cannot tear it.
                        state       <= ACTIVE;
                        cnt         <= '0;
                        seg_snap    <= digit_pick;
                        dp_snap     <= dots[idx];
                        bright_snap <= brightness;
                        seg         <= seg_phys(digit_pick, 1'b1);
                        dp          <= dp_phys(dots[idx], 1'b1);
                        digit_sel   <= sel_phys(idx, 1'b1);
                    end else begin
                        cnt       <= cnt + 1'b1;
                        seg       <= seg_phys(seg_snap, 1'b0);
                        dp        <= dp_phys(dp_snap, 1'b0);
                        digit_sel <= sel_phys(idx, 1'b0);
                    end
                end
                ACTIVE: begin
                    frame_start <= 1'b0;
                    if (cnt == SUB_LAST) begin
                        cnt <= '0;
                        if (sub == 4'd15) begin
                            state       <= BLANK;
                            idx         <= idx + 2'd1;
                            sub         <= 4'd0;
                            seg         <= seg_phys(seg_snap, 1'b0);
                            dp          <= dp_phys(dp_snap, 1'b0);
                            digit_sel   <= sel_phys(idx, 1'b0);
                            frame_start <= (idx == 2'd3);
                        end else begin
                            sub       <= sub + 4'd1;
                            seg       <= seg_phys(seg_snap, (sub + 4'd1) <= bright_snap);
                            dp        <= dp_phys(dp_snap, (sub + 4'd1) <= bright_snap);
                            digit_sel <= sel_phys(idx, (sub + 4'd1) <= bright_snap);
                        end
                    end else begin
                        cnt       <= cnt + 1'b1;
                        seg       <= seg_phys(seg_snap, sub <= bright_snap);
                        dp        <= dp_phys(dp_snap, sub <= bright_snap);
                        digit_sel <= sel_phys(idx, sub <= bright_snap);
                    end
                end
                default: begin
                    state       <= IDLE;
                    idx         <= 2'd0;
                    cnt         <= '0;
                    sub         <= 4'd0;
                    seg         <= seg_phys(seg_snap, 1'b0);
                    dp          <= dp_phys(dp_snap, 1'b0);
                    digit_sel   <= sel_phys(2'd0, 1'b0);
                    frame_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssds_scan_controller.sv
// Bench for ssds_scan_controller: directed steps plus random traffic, checked every
// cycle against a slot/position timeline model of the scan.
module tb_ssds_scan_controller;

    localparam int SUB   = 2;
    localparam int BLK   = 3;
    localparam int SLOT  = BLK + 16 * SUB;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [6:0] digs [4];
    logic [3:0] dots, brightness;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] digit_sel;
    logic       frame_start;

    always #5 clk = ~clk;

    ssds_scan_controller #(.SUB_DIV(SUB), .BLANK_CYCLES(BLK), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en),
        .digit_0(digs[0]), .digit_1(digs[1]), .digit_2(digs[2]), .digit_3(digs[3]),
        .dots(dots), .brightness(brightness),
        .seg(seg), .dp(dp), .digit_sel(digit_sel), .frame_start(frame_start)
    );

    int checks = 0;
    int errors = 0;

    // Model: m_e is the cycle position within the frame since the scan started.
    bit         m_run = 1'b0;
    int         m_e = 0;
    int         m_slot, m_pos;
    logic [6:0] m_seg = 7'h00;
    logic       m_dp = 1'b0;
    logic [3:0] m_b = 4'd0;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [3:0] exp_sel;
    logic       exp_fs;

    task automatic model_step();
        if (!rst || !en) m_run = 1'b0;
        else if (!m_run) begin
            m_run = 1'b1;
            m_e   = 0;
        end else m_e = (m_e + 1) % FRAME;
        exp_seg = 7'h7F; exp_dp = 1'b1; exp_sel = 4'hF; exp_fs = 1'b0;
        if (m_run) begin
            m_slot = m_e / SLOT;
            m_pos  = m_e % SLOT;
            if (m_pos < BLK) exp_fs = (m_pos == 0 && m_slot == 0);
            else begin
                if (m_pos == BLK) begin
                    m_seg = digs[m_slot];
                    m_dp  = dots[m_slot];
                    m_b   = brightness;
                end
                if ((m_pos - BLK) / SUB <= int'(m_b)) begin
                    exp_seg = ~m_seg;
                    exp_dp  = ~m_dp;
                    exp_sel = ~(4'b0001 << m_slot);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        checks++;
        assert ({seg, dp, digit_sel, frame_start} === {exp_seg, exp_dp, exp_sel, exp_fs}) else begin
            errors++;
            $error("FAIL model e=%0d: seg=%h dp=%b sel=%b fs=%b expected seg=%h dp=%b sel=%b fs=%b",
                   m_e, seg, dp, digit_sel, frame_start, exp_seg, exp_dp, exp_sel, exp_fs);
        end
        checks++;
        assert ($countones(~digit_sel) <= 1) else begin
            errors++;
            $error("FAIL onehot: digit_sel=%b expected at most one low bit", digit_sel);
        end
    endtask

    task automatic expect_out(input string tag, input logic [6:0] s, input logic d,
                              input logic [3:0] sel, input logic fs);
        checks++;
        assert ({seg, dp, digit_sel, frame_start} === {s, d, sel, fs}) else begin
            errors++;
            $error("FAIL %s: seg=%h dp=%b sel=%b fs=%b expected seg=%h dp=%b sel=%b fs=%b",
                   tag, seg, dp, digit_sel, frame_start, s, d, sel, fs);
        end
    endtask

    task automatic wait_e(input int target);
        int n = 0;
        while (!(m_run && m_e == target) && n < FRAME + 10) begin
            tick();
            n++;
        end
        checks++;
        assert (m_run && m_e == target) else begin
            errors++;
            $error("FAIL wait_e: position %0d reached=%0d expected=1", target, 0);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1;
        digs[0] = 7'h06; digs[1] = 7'h5B; digs[2] = 7'h4F; digs[3] = 7'h66;
        dots = 4'b0001; brightness = 4'd15;

        tick(); tick();
        expect_out("reset", 7'h7F, 1'b1, 4'hF, 1'b0);

        rst = 1'b1;
        tick();
        expect_out("fs_first", 7'h7F, 1'b1, 4'hF, 1'b1);
        tick(); tick(); tick();
        expect_out("d0_on", 7'h79, 1'b0, 4'b1110, 1'b0);
        repeat (31) tick();
        expect_out("d0_last", 7'h79, 1'b0, 4'b1110, 1'b0);
        tick();
        expect_out("blank1", 7'h7F, 1'b1, 4'hF, 1'b0);
        tick(); tick(); tick();
        expect_out("d1_on", 7'h24, 1'b1, 4'b1101, 1'b0);
        wait_e(FRAME - 1);
        tick();
        expect_out("fs_frame2", 7'h7F, 1'b1, 4'hF, 1'b1);

        brightness = 4'd3;
        tick(); tick(); tick();
        expect_out("b3_on", 7'h79, 1'b0, 4'b1110, 1'b0);
        repeat (7) tick();
        expect_out("b3_last", 7'h79, 1'b0, 4'b1110, 1'b0);
        tick();
        expect_out("b3_off", 7'h7F, 1'b1, 4'hF, 1'b0);

        wait_e(SLOT + BLK + 5);
        digs[1] = 7'h3F;
        tick();
        expect_out("snap_hold", 7'h24, 1'b1, 4'b1101, 1'b0);
        wait_e(SLOT + BLK);
        expect_out("d1_new", 7'h40, 1'b1, 4'b1101, 1'b0);

        wait_e(2 * SLOT + BLK + 2);
        en = 1'b0;
        tick();
        expect_out("en_off", 7'h7F, 1'b1, 4'hF, 1'b0);
        tick(); tick();
        en = 1'b1;
        tick();
        expect_out("reen_fs", 7'h7F, 1'b1, 4'hF, 1'b1);
        tick(); tick(); tick();
        expect_out("reen_d0", 7'h79, 1'b0, 4'b1110, 1'b0);

        wait_e(SLOT + BLK + 1);
        rst = 1'b0;
        tick();
        expect_out("rst_off", 7'h7F, 1'b1, 4'hF, 1'b0);
        rst = 1'b1;
        tick();
        expect_out("rst_fs", 7'h7F, 1'b1, 4'hF, 1'b1);
        tick(); tick(); tick();
        expect_out("rst_d0", 7'h79, 1'b0, 4'b1110, 1'b0);

        brightness = 4'd0;
        wait_e(SLOT + BLK);
        expect_out("b0_on", 7'h40, 1'b1, 4'b1101, 1'b0);
        tick(); tick();
        expect_out("b0_off", 7'h7F, 1'b1, 4'hF, 1'b0);

        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) digs[$urandom_range(0, 3)] = 7'($urandom);
            if ($urandom_range(0, 29) == 0) dots = 4'($urandom);
            if ($urandom_range(0, 49) == 0) brightness = 4'($urandom);
            en  = ($urandom_range(0, 399) != 0);
            rst = ($urandom_range(0, 899) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
